bcd_set_counter: RTL
====================

# bcd_set_counter

Parametrised multi-digit BCD setting counter for the alarm-clock time/alarm set path. It advances at most once per arming cycle on an enable qualified by the set FSM, counts up or down between MIN_VAL and MAX_VAL, and either wraps or saturates at the limits. It also supports a synchronous range-checked load and flags the limits to the FSM. It replaces per-digit 0..9 set counters: one instance covers minutes (00..59), hours (00..23 or 01..12) or a single digit.

## Interface
- DIGITS, 2: number of BCD digits; q width is 4*DIGITS.
- MAX_VAL, 59: upper limit, decimal integer; must satisfy MAX_VAL < 10**DIGITS.
- MIN_VAL, 0: lower limit and reset value; must satisfy MIN_VAL <= MAX_VAL.
- WRAP, 1: 1 = wrap at the limits; 0 = saturate at the limits.
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  step enable from the set FSM; level input, qualified by the arm flag.
- inc  in  1  step up request.
- dec  in  1  step down request.
- rearm  in  1  re-arms stepping; driven by the FSM from another state.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD value to load.
- q  out  4*DIGITS  current value in BCD; the least-significant digit is q[3:0].
- at_max  out  1  high while q == MAX_VAL.
- at_min  out  1  high while q == MIN_VAL.
- carry  out  1  one-cycle pulse when an up step wraps MAX_VAL to MIN_VAL.
- borrow  out  1  one-cycle pulse when a down step wraps MIN_VAL to MAX_VAL.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Internal state: q register and `armed` flag.
- Reset (reset_n low): q = MIN_VAL in BCD, armed = 1, carry/borrow/load_err = 0, at_min = 1, at_max = (MIN_VAL == MAX_VAL).
- Step request: en & armed & (inc ^ dec). This is the only event that changes q, apart from load.
- Priority per cycle: load > step > re-arm.
- Load, valid case: every nibble of load_val is <= 9 and MIN_VAL <= value <= MAX_VAL. Then q <= load_val and armed <= 1.
- Load, invalid case: q is unchanged, load_err pulses, armed is unchanged. Load while a step is requested suppresses the step.
- Up step, q < MAX_VAL: BCD increment. A digit at 9 becomes 0 and carries into the next digit.
- Up step, q == MAX_VAL: with WRAP=1, q <= MIN_VAL and carry pulses. With WRAP=0, q holds and there is no pulse.
- Down step mirrors the up step: BCD decrement, a digit at 0 becomes 9 and borrows from the next digit. At MIN_VAL it wraps to MAX_VAL with a borrow pulse (WRAP=1) or holds (WRAP=0).
- Any step request clears armed, including a saturated no-change step.
- inc & dec both high: no step, armed unchanged.
- Re-arm: armed <= 1 when rearm is high or en is low, provided no step or load occurs in that cycle.
- With armed == 0 and en held high, further inc/dec requests are ignored.
- at_max and at_min are decoded combinationally from the q register, so they are always consistent with q.

## Timing
- Step latency: request sampled at edge N, new q visible after edge N. The carry/borrow pulse is coincident with the new q for exactly one cycle.
- Load latency is also one edge; load_err is coincident with the cycle after the strobe.
- Earliest second step after an en pulse of length 1: the next cycle with en low re-arms, so the second step lands at edge N+2.
- A reset_n assertion mid-step overrides immediately, with no dependence on clk. Deassertion takes effect at the next clk edge.
- No combinational path from inputs to outputs.

## Structure
- Shared package bcd_pkg:
  - bcd_digit_t (4-bit digit type).
  - BCD_MAX_DIGIT = 9.
  - Function to_bcd(int, DIGITS) for converting MIN_VAL/MAX_VAL into BCD constants at elaboration.
- Sub-module bcd_digit: one 4-bit digit with ports up, down, cin/bin, cout/bout and a next-value output. The top level chains DIGITS instances with generate and applies limit compare, wrap/saturate, load check and arm logic.
- Target size: 150-250 lines of RTL in total.

## Test plan
- Reset, then DIGITS=2, MAX=59: with en=1, inc=1, toggle rearm each cycle for 59 steps. Expect q 00→59 with a correct 09→10 BCD carry, at_max=1 at 59. One more step gives q=00, carry=1 for one cycle, at_min=1.
- Hold en=1, inc=1 for 10 cycles with rearm=0. Expect exactly one step (00→01); dropping en for 1 cycle and raising it again gives 01→02.
- WRAP=0, MIN=1, MAX=12, q=01: one dec step leaves q=01 with borrow=0. Load 12, then one inc step leaves q=12 with at_max=1.
- MAX=23: load 8'h24 → load_err pulse, q unchanged. Load 8'h1A → load_err. Load 8'h23 → q=23, no error. Load and inc in the same cycle → loaded value only.
- inc=dec=1 with armed=1 → q unchanged and armed stays 1; the next inc-only request steps.
- Assert reset_n low between clk edges during a step → q=MIN_VAL immediately; outputs match their reset values before the next edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and elaboration-time conversion helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Widest counter to_bcd can describe.
    localparam int unsigned BCD_MAX_DIGITS = 8;

    // Convert a binary integer into packed BCD, least-significant digit in [3:0].
    function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int value, input int digits);
        logic [4*BCD_MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < int'(BCD_MAX_DIGITS); i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the step datapath: increment/decrement with carry/borrow chaining.
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    input  logic       up,
    input  logic       down,
    input  logic       cin,
    input  logic       bin,
    output bcd_digit_t nxt,
    output logic       cout,
    output logic       bout
);

    // Next digit value and ripple into the next digit.
    always_comb begin
        nxt  = d;
        cout = 1'b0;
        bout = 1'b0;
        if (up && cin) begin
            if (d >= BCD_MAX_DIGIT) begin
                nxt  = 4'd0;
                cout = 1'b1;
            end else begin
                nxt = d + 4'd1;
            end
        end else if (down && bin) begin
            if (d == 4'd0) begin
                nxt  = BCD_MAX_DIGIT;
                bout = 1'b1;
            end else begin
                nxt = d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_set_counter.sv
// Multi-digit BCD set counter with arm-qualified stepping, wrap/saturate and checked load.
module bcd_set_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MAX_VAL = 59,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned WRAP    = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                inc,
    input  logic                dec,
    input  logic                rearm,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                at_max,
    output logic                at_min,
    output logic                carry,
    output logic                borrow,
    output logic                load_err
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] MAX_BCD = W'(to_bcd(int'(MAX_VAL), int'(DIGITS)));
    localparam logic [W-1:0] MIN_BCD = W'(to_bcd(int'(MIN_VAL), int'(DIGITS)));

    logic          armed;
    logic          armed_nxt;
    logic [W-1:0]  q_nxt;
    logic          carry_nxt;
    logic          borrow_nxt;
    logic          load_err_nxt;
    logic          step_req;
    logic          up;
    logic          down;
    logic          load_ok;
    logic [W-1:0]  step_val;
    logic [DIGITS:0] cin;
    logic [DIGITS:0] bin;
    logic          unused_chain;

    assign up       = inc & ~dec;
    assign down     = dec & ~inc;
    assign step_req = en & armed & (inc ^ dec);
    assign cin[0]   = 1'b1;
    assign bin[0]   = 1'b1;

    // Out-of-range carry/borrow never reaches q: the limit compare handles the top end.
    assign unused_chain = cin[DIGITS] ^ bin[DIGITS];

    // Digit chain producing the plain BCD +1/-1 of q.
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        bcd_digit u_digit (
            .d    (q[4*g +: 4]),
            .up   (up),
            .down (down),
            .cin  (cin[g]),
            .bin  (bin[g]),
            .nxt  (step_val[4*g +: 4]),
            .cout (cin[g+1]),
            .bout (bin[g+1])
        );
    end

    // Limit flags decoded from the q register only.
    assign at_max = (q == MAX_BCD);
    assign at_min = (q == MIN_BCD);

    // Load acceptance: every nibble a decimal digit and the value inside the range.
    always_comb begin
        load_ok = (load_val >= MIN_BCD) && (load_val <= MAX_BCD);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val[4*i +: 4] > BCD_MAX_DIGIT) begin
                load_ok = 1'b0;
            end
        end
    end

    // Next state: load beats step, step beats re-arm.
    always_comb begin
        q_nxt        = q;
        armed_nxt    = armed;
        carry_nxt    = 1'b0;
        borrow_nxt   = 1'b0;
        load_err_nxt = 1'b0;
        if (load) begin
            if (load_ok) begin
                q_nxt     = load_val;
                armed_nxt = 1'b1;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (step_req) begin
            armed_nxt = 1'b0;
            if (up) begin
                if (at_max) begin
                    if (WRAP != 0) begin
                        q_nxt     = MIN_BCD;
                        carry_nxt = 1'b1;
                    end
                end else begin
                    q_nxt = step_val;
                end
            end else begin
                if (at_min) begin
                    if (WRAP != 0) begin
                        q_nxt      = MAX_BCD;
                        borrow_nxt = 1'b1;
                    end
                end else begin
                    q_nxt = step_val;
                end
            end
        end else if (rearm || !en) begin
            armed_nxt = 1'b1;
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q        <= MIN_BCD;
            armed    <= 1'b1;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_nxt;
            armed    <= armed_nxt;
            carry    <= carry_nxt;
            borrow   <= borrow_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule
